// File: rtl/ram_arb_pkg.sv
// Shared types for the program/data RAM arbiter.
//   owner_e   : which requester currently holds a lock on the RAM
//   req_sel_e : requester identity, used for the round-robin history
//   DEF_AW/DEF_DW : default address/data widths of the 256 x 8 RAM
package ram_arb_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_LDR  = 2'd2
    } owner_e;

    typedef enum logic {
        SEL_CPU = 1'b0,
        SEL_LDR = 1'b1
    } req_sel_e;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker.
//   req[0] = CPU, req[1] = loader
//   last   : requester served most recently
//   sel    : one-hot pick (2'b00 when nothing requests)
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_sel_e   last,
    output logic [1:0] sel
);

    always_comb begin
        sel = 2'b00;
        case (req)
            2'b01:   sel = 2'b01;
            2'b10:   sel = 2'b10;
            // On a tie the requester not served last goes first.
            2'b11:   sel = (last == SEL_LDR) ? 2'b01 : 2'b10;
            default: sel = 2'b00;
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Shares the single 256 x 8 program/data RAM between the CPU and the
// loader/debug port. One single-cycle access is granted per clock;
// read data comes back registered one cycle after the grant. A requester
// may lock the RAM for a bounded number of cycles (MAX_LOCK).
// Ports:
//   clk, rst                  : clock, synchronous active-high reset
//   cpu_* / ldr_*             : request (req/we/lock/addr/wdata) and
//                               response (gnt/rvalid/rdata) per requester
//   mem_we, mem_w_addr/data   : RAM write port
//   mem_r_addr, mem_r_data    : RAM combinational read port
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_LOCK = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic          cpu_lock,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_gnt,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          ldr_req,
    input  logic          ldr_we,
    input  logic          ldr_lock,
    input  logic [AW-1:0] ldr_addr,
    input  logic [DW-1:0] ldr_wdata,
    output logic          ldr_gnt,
    output logic          ldr_rvalid,
    output logic [DW-1:0] ldr_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_w_addr,
    output logic [DW-1:0] mem_w_data,
    output logic [AW-1:0] mem_r_addr,
    input  logic [DW-1:0] mem_r_data
);

    localparam int CW = $clog2(MAX_LOCK + 1);

    owner_e        owner;
    req_sel_e      last;
    logic [CW-1:0] lock_cnt;
    logic [AW-1:0] addr_hold;
    logic [DW-1:0] wdata_hold;

    logic [1:0]    rr_sel;
    logic          gnt_c;
    logic          gnt_l;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic          g_we;
    logic          lock_full;

    arb_rr2 u_rr (
        .req  ({ldr_req, cpu_req}),
        .last (last),
        .sel  (rr_sel)
    );

    assign lock_full = (lock_cnt == CW'(MAX_LOCK));

    // Zero-cycle grant from the request lines and the registered owner.
    always_comb begin
        gnt_c = 1'b0;
        gnt_l = 1'b0;
        if (!rst) begin
            case (owner)
                OWN_NONE: begin
                    gnt_c = rr_sel[0];
                    gnt_l = rr_sel[1];
                end
                OWN_CPU: gnt_c = cpu_req;
                OWN_LDR: gnt_l = ldr_req;
                default: ;
            endcase
        end
    end

    // Granted requester steers the RAM ports; idle cycles replay the
    // last granted address/data with the write strobe off.
    always_comb begin
        g_addr  = addr_hold;
        g_wdata = wdata_hold;
        g_we    = 1'b0;
        if (gnt_c) begin
            g_addr  = cpu_addr;
            g_wdata = cpu_wdata;
            g_we    = cpu_we;
        end else if (gnt_l) begin
            g_addr  = ldr_addr;
            g_wdata = ldr_wdata;
            g_we    = ldr_we;
        end
    end

    assign cpu_gnt    = gnt_c;
    assign ldr_gnt    = gnt_l;
    assign mem_we     = g_we;
    assign mem_w_addr = g_addr;
    assign mem_r_addr = g_addr;
    assign mem_w_data = g_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            owner      <= OWN_NONE;
            last       <= SEL_LDR;
            lock_cnt   <= '0;
            addr_hold  <= '0;
            wdata_hold <= '0;
            cpu_rvalid <= 1'b0;
            ldr_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            ldr_rdata  <= '0;
        end else begin
            cpu_rvalid <= gnt_c & ~cpu_we;
            ldr_rvalid <= gnt_l & ~ldr_we;
            if (gnt_c && !cpu_we) cpu_rdata <= mem_r_data;
            if (gnt_l && !ldr_we) ldr_rdata <= mem_r_data;

            if (gnt_c || gnt_l) begin
                addr_hold  <= g_addr;
                wdata_hold <= g_wdata;
            end

            if (gnt_c)      last <= SEL_CPU;
            else if (gnt_l) last <= SEL_LDR;

            case (owner)
                OWN_NONE: begin
                    if (gnt_c && cpu_lock) begin
                        owner    <= OWN_CPU;
                        lock_cnt <= CW'(1);
                    end else if (gnt_l && ldr_lock) begin
                        owner    <= OWN_LDR;
                        lock_cnt <= CW'(1);
                    end
                end
                OWN_CPU: begin
                    // Forced release wins over lock; the CPU counts as
                    // served so a waiting loader goes next.
                    if (lock_full) begin
                        owner    <= OWN_NONE;
                        lock_cnt <= '0;
                        last     <= SEL_CPU;
                    end else if (gnt_c && !cpu_lock) begin
                        owner    <= OWN_NONE;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                OWN_LDR: begin
                    if (lock_full) begin
                        owner    <= OWN_NONE;
                        lock_cnt <= '0;
                        last     <= SEL_LDR;
                    end else if (gnt_l && !ldr_lock) begin
                        owner    <= OWN_NONE;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CW'(1);
                    end
                end
                default: begin
                    owner    <= OWN_NONE;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with MAX_LOCK = 4 and a behavioural
// 256 x 8 RAM (write on the rising edge, combinational read).
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_lock;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          ldr_req, ldr_we, ldr_lock;
    logic [AW-1:0] ldr_addr;
    logic [DW-1:0] ldr_wdata;
    logic          ldr_gnt, ldr_rvalid;
    logic [DW-1:0] ldr_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_w_addr, mem_r_addr;
    logic [DW-1:0] mem_w_data, mem_r_data;

    logic [DW-1:0] ram [256];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_w_addr] <= mem_w_data;
    end
    assign mem_r_data = ram[mem_r_addr];

    ram_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_lock   (cpu_lock),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .ldr_req    (ldr_req),
        .ldr_we     (ldr_we),
        .ldr_lock   (ldr_lock),
        .ldr_addr   (ldr_addr),
        .ldr_wdata  (ldr_wdata),
        .ldr_gnt    (ldr_gnt),
        .ldr_rvalid (ldr_rvalid),
        .ldr_rdata  (ldr_rdata),
        .mem_we     (mem_we),
        .mem_w_addr (mem_w_addr),
        .mem_w_data (mem_w_data),
        .mem_r_addr (mem_r_addr),
        .mem_r_data (mem_r_data)
    );

    task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic lock,
                           input logic [7:0] addr, input logic [7:0] wdata);
        cpu_req = req; cpu_we = we; cpu_lock = lock; cpu_addr = addr; cpu_wdata = wdata;
    endtask

    task automatic set_ldr(input logic req, input logic we, input logic lock,
                           input logic [7:0] addr, input logic [7:0] wdata);
        ldr_req = req; ldr_we = we; ldr_lock = lock; ldr_addr = addr; ldr_wdata = wdata;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with both requesting: grants must be gated.
        rst = 1'b1;
        set_cpu(1'b1, 1'b1, 1'b0, 8'h55, 8'hFF);
        set_ldr(1'b1, 1'b1, 1'b0, 8'h66, 8'hEE);
        @(negedge clk);
        chk_vec("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk_vec("rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
        chk_vec("rst_mem_we", 32'(mem_we), 32'd0);
        chk_vec("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk_vec("rst_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        chk_vec("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk_vec("rst_mem_r_addr", 32'(mem_r_addr), 32'd0);
        chk_vec("rst_mem_w_data", 32'(mem_w_data), 32'd0);
        chk_vec("rst_owner", 32'(dut.owner), 32'(OWN_NONE));
        chk_vec("rst_lock_cnt", 32'(dut.lock_cnt), 32'd0);
        tick;
        rst = 1'b0;

        // CPU write 0xA1 to 0x05, then read it back.
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_cpu(1'b1, 1'b1, 1'b0, 8'h05, 8'hA1);
        @(negedge clk);
        chk_vec("wr_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk_vec("wr_mem_we", 32'(mem_we), 32'd1);
        chk_vec("wr_mem_w_addr", 32'(mem_w_addr), 32'h05);
        chk_vec("wr_mem_w_data", 32'(mem_w_data), 32'hA1);
        tick;
        set_cpu(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
        @(negedge clk);
        chk_vec("rd_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk_vec("rd_mem_we", 32'(mem_we), 32'd0);
        chk_vec("rd_mem_r_addr", 32'(mem_r_addr), 32'h05);
        chk_vec("wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
        tick;
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_vec("rd_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        chk_vec("rd_cpu_rdata", 32'(cpu_rdata), 32'hA1);
        chk_vec("idle_cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk_vec("idle_mem_we", 32'(mem_we), 32'd0);
        chk_vec("idle_addr_hold", 32'(mem_r_addr), 32'h05);
        tick;

        // Fresh reset, then a continuous unlocked tie: C L C L C.
        rst = 1'b1;
        tick;
        rst = 1'b0;
        set_cpu(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
        set_ldr(1'b1, 1'b0, 1'b0, 8'h07, 8'h00);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_vec($sformatf("tie%0d_cpu_gnt", i), 32'(cpu_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk_vec($sformatf("tie%0d_ldr_gnt", i), 32'(ldr_gnt), (i % 2 == 1) ? 32'd1 : 32'd0);
            if (i > 0)
                chk_vec($sformatf("tie%0d_cpu_rvalid", i), 32'(cpu_rvalid), (i % 2 == 1) ? 32'd1 : 32'd0);
            tick;
        end

        // Loader locks and writes 0x10..0x13 to 0..3 while the CPU waits.
        for (int k = 0; k < 4; k++) begin
            set_ldr(1'b1, 1'b1, (k < 3), 8'(k), 8'(8'h10 + k));
            set_cpu(1'b1, 1'b0, 1'b0, 8'h02, 8'h00);
            @(negedge clk);
            chk_vec($sformatf("lk%0d_ldr_gnt", k), 32'(ldr_gnt), 32'd1);
            chk_vec($sformatf("lk%0d_cpu_gnt", k), 32'(cpu_gnt), 32'd0);
            chk_vec($sformatf("lk%0d_w_addr", k), 32'(mem_w_addr), 32'(k));
            chk_vec($sformatf("lk%0d_w_data", k), 32'(mem_w_data), 32'(8'h10 + k));
            tick;
        end
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_vec("lk_release_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick;
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_vec("lk_rd_rdata", 32'(cpu_rdata), 32'h12);
        tick;

        // Forced release: loader keeps lock and req high, CPU waiting.
        // One grant takes the lock, then MAX_LOCK owned cycles, then CPU.
        set_ldr(1'b1, 1'b0, 1'b1, 8'h01, 8'h00);
        set_cpu(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk_vec($sformatf("fr%0d_ldr_gnt", i), 32'(ldr_gnt), (i <= ML) ? 32'd1 : 32'd0);
            chk_vec($sformatf("fr%0d_cpu_gnt", i), 32'(cpu_gnt), (i == ML + 1) ? 32'd1 : 32'd0);
            if (i >= 1 && i <= ML)
                chk_vec($sformatf("fr%0d_lock_cnt", i), 32'(dut.lock_cnt), 32'(i));
            if (i == 1)
                chk_vec("fr_ldr_rdata", 32'(ldr_rdata), 32'h11);
            if (i == ML + 1)
                chk_vec("fr_owner", 32'(dut.owner), 32'(OWN_NONE));
            tick;
        end
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Reset while the loader owns the RAM with a read just granted.
        set_ldr(1'b1, 1'b0, 1'b1, 8'h02, 8'h00);
        @(negedge clk);
        chk_vec("rm_take_ldr_gnt", 32'(ldr_gnt), 32'd1);
        tick;
        set_ldr(1'b1, 1'b0, 1'b1, 8'h03, 8'h00);
        @(negedge clk);
        chk_vec("rm_read_ldr_gnt", 32'(ldr_gnt), 32'd1);
        tick;
        rst = 1'b1;
        set_ldr(1'b1, 1'b1, 1'b1, 8'h00, 8'hEE);
        set_cpu(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_vec("rm_rst_ldr_gnt", 32'(ldr_gnt), 32'd0);
        chk_vec("rm_rst_mem_we", 32'(mem_we), 32'd0);
        tick;
        rst = 1'b0;
        set_ldr(1'b1, 1'b0, 1'b0, 8'h03, 8'h00);
        @(negedge clk);
        chk_vec("rm_ldr_rvalid", 32'(ldr_rvalid), 32'd0);
        chk_vec("rm_owner", 32'(dut.owner), 32'(OWN_NONE));
        chk_vec("rm_lock_cnt", 32'(dut.lock_cnt), 32'd0);
        chk_vec("rm_cpu_first", 32'(cpu_gnt), 32'd1);
        chk_vec("rm_ldr_wait", 32'(ldr_gnt), 32'd0);
        tick;
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_vec("rm_no_write_rdata", 32'(cpu_rdata), 32'h10);
        chk_vec("rm_ldr_next", 32'(ldr_gnt), 32'd1);
        tick;
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);

        // Idle owner: CPU locks then stops requesting; loader waits.
        set_cpu(1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
        set_ldr(1'b1, 1'b1, 1'b0, 8'h20, 8'h77);
        @(negedge clk);
        chk_vec("io_take_cpu_gnt", 32'(cpu_gnt), 32'd1);
        tick;
        set_cpu(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        for (int i = 1; i <= ML; i++) begin
            @(negedge clk);
            chk_vec($sformatf("io%0d_ldr_gnt", i), 32'(ldr_gnt), 32'd0);
            chk_vec($sformatf("io%0d_mem_we", i), 32'(mem_we), 32'd0);
            chk_vec($sformatf("io%0d_lock_cnt", i), 32'(dut.lock_cnt), 32'(i));
            tick;
        end
        @(negedge clk);
        chk_vec("io_owner", 32'(dut.owner), 32'(OWN_NONE));
        chk_vec("io_ldr_gnt", 32'(ldr_gnt), 32'd1);
        chk_vec("io_mem_we", 32'(mem_we), 32'd1);
        chk_vec("io_w_addr", 32'(mem_w_addr), 32'h20);
        tick;
        // Read-after-write on the next cycle sees the new data.
        set_ldr(1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        @(negedge clk);
        chk_vec("raw_ldr_gnt", 32'(ldr_gnt), 32'd1);
        tick;
        set_ldr(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        chk_vec("raw_ldr_rvalid", 32'(ldr_rvalid), 32'd1);
        chk_vec("raw_ldr_rdata", 32'(ldr_rdata), 32'h77);
        tick;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
